// File: rtl/simple_spi_master_pkg.sv
// Shared state encoding for the mode-0 SPI master.
package simple_spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } spi_state_e;

endpackage

// File: rtl/simple_spi_master.sv
// Mode-0 (CPOL=0, CPHA=0) MSB-first SPI master with a start/busy/done word handshake.
// All pin outputs come straight from flops; SPI clock is system_clk / (2*HALF_PERIOD).
module simple_spi_master
    import simple_spi_master_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int HALF_PERIOD = 4
) (
    input  logic             system_clk,
    input  logic             system_rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] value_mosi,
    output logic [WIDTH-1:0] value_miso,
    output logic             busy,
    output logic             done,
    output logic             pin_ncs,
    output logic             pin_clk,
    output logic             pin_mosi,
    input  logic             pin_miso
);

    localparam int PW = $clog2(HALF_PERIOD + 1);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [PW-1:0] PH_LOAD  = PW'(HALF_PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    spi_state_e       state_q, state_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] value_miso_q, value_miso_d;
    logic             ncs_q, ncs_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             phase_end;

    assign phase_end = (phase_q == '0);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        bit_cnt_d    = bit_cnt_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        value_miso_d = value_miso_q;
        ncs_d        = ncs_q;
        sclk_d       = sclk_q;
        mosi_d       = mosi_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        if (state_q != IDLE) begin
            phase_d = phase_end ? PH_LOAD : phase_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    // tx holds the bits still to be sent, next one in the MSB
                    tx_d      = {value_mosi[WIDTH-2:0], 1'b0};
                    ncs_d     = 1'b0;
                    mosi_d    = value_mosi[WIDTH-1];
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                    phase_d   = PH_LOAD;
                    state_d   = SETUP;
                end
            end
            SETUP, LOW: begin
                if (phase_end) begin
                    sclk_d  = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    rx_d      = {rx_q[WIDTH-2:0], pin_miso};
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        mosi_d  = tx_q[WIDTH-1];
                        tx_d    = {tx_q[WIDTH-2:0], 1'b0};
                        state_d = LOW;
                    end
                end
            end
            HOLD: begin
                if (phase_end) begin
                    ncs_d        = 1'b1;
                    mosi_d       = 1'b0;
                    value_miso_d = rx_q;
                    done_d       = 1'b1;
                    state_d      = GAP;
                end
            end
            GAP: begin
                if (phase_end) begin
                    busy_d    = 1'b0;
                    phase_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge system_clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            bit_cnt_q    <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            value_miso_q <= '0;
            ncs_q        <= 1'b1;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            value_miso_q <= value_miso_d;
            ncs_q        <= ncs_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign value_miso = value_miso_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pin_ncs    = ncs_q;
    assign pin_clk    = sclk_q;
    assign pin_mosi   = mosi_q;

endmodule

// File: tb/tb_simple_spi_master.sv
// Bench for simple_spi_master: a behavioural mode-0 slave on a W=4/H=4 instance and a
// mosi->miso loopback on a W=8/H=1 instance, both sharing clock and reset.
module tb_simple_spi_master;

    localparam int WA    = 4;
    localparam int HA    = 4;
    localparam int WB    = 8;
    localparam int HB    = 1;
    localparam int LAT_A = (2 * WA + 1) * HA + 1;
    localparam int LAT_B = (2 * WB + 1) * HB + 1;

    logic system_clk   = 1'b0;
    logic system_rst_n = 1'b0;

    logic          start_a    = 1'b0;
    logic [WA-1:0] mosi_in_a  = '0;
    logic [WA-1:0] miso_out_a;
    logic          busy_a, done_a, ncs_a, sclk_a, mosi_a;
    logic          miso_a     = 1'b0;

    logic          start_b    = 1'b0;
    logic [WB-1:0] mosi_in_b  = '0;
    logic [WB-1:0] miso_out_b;
    logic          busy_b, done_b, ncs_b, sclk_b, mosi_b;

    int checks = 0;
    int errors = 0;

    always #5 system_clk = ~system_clk;

    simple_spi_master #(.WIDTH(WA), .HALF_PERIOD(HA)) dut_a (
        .system_clk  (system_clk),
        .system_rst_n(system_rst_n),
        .start       (start_a),
        .value_mosi  (mosi_in_a),
        .value_miso  (miso_out_a),
        .busy        (busy_a),
        .done        (done_a),
        .pin_ncs     (ncs_a),
        .pin_clk     (sclk_a),
        .pin_mosi    (mosi_a),
        .pin_miso    (miso_a)
    );

    simple_spi_master #(.WIDTH(WB), .HALF_PERIOD(HB)) dut_b (
        .system_clk  (system_clk),
        .system_rst_n(system_rst_n),
        .start       (start_b),
        .value_mosi  (mosi_in_b),
        .value_miso  (miso_out_b),
        .busy        (busy_b),
        .done        (done_b),
        .pin_ncs     (ncs_b),
        .pin_clk     (sclk_b),
        .pin_mosi    (mosi_b),
        .pin_miso    (mosi_b)
    );

    // Slave model for dut_a: shifts slv_word out MSB first, advancing on each falling
    // SPI clock, and collects mosi on each rising SPI clock.
    logic [WA-1:0] slv_word = '0;
    logic [WA-1:0] slv_rx   = '0;
    int slv_k = 0, rises_a = 0, frames_a = 0, dones_a = 0, mosi_viol_a = 0, ncs_hi_a = 0;
    int gap_log[$];
    logic p_ncs_a = 1'b1, p_clk_a = 1'b0, p_mosi_a = 1'b0;

    int rises_b = 0, hi_run_b = 0, lo_run_b = 0, hi_max_b = 0, lo_max_b = 0, mosi_viol_b = 0;
    logic p_ncs_b = 1'b1, p_clk_b = 1'b0, p_mosi_b = 1'b0;

    initial begin
        forever begin
            @(negedge system_clk);
            if (!system_rst_n) begin
                ncs_hi_a = 0;
            end else begin
                if (p_ncs_a && !ncs_a) begin
                    gap_log.push_back(ncs_hi_a);
                    ncs_hi_a = 0;
                    frames_a++;
                    rises_a  = 0;
                    slv_k    = 0;
                    slv_rx   = '0;
                    miso_a   = slv_word[WA-1];
                end
                if (ncs_a) ncs_hi_a++;
                if (!p_clk_a && sclk_a) begin
                    slv_rx = {slv_rx[WA-2:0], mosi_a};
                    rises_a++;
                end
                if (p_clk_a && !sclk_a && !ncs_a) begin
                    slv_k++;
                    if (slv_k < WA) miso_a = slv_word[WA-1-slv_k];
                end
                if (mosi_a !== p_mosi_a && sclk_a) mosi_viol_a++;
                if (done_a) dones_a++;

                if (p_ncs_b && !ncs_b) begin
                    rises_b = 0; hi_max_b = 0; lo_max_b = 0; hi_run_b = 0; lo_run_b = 0;
                end
                if (!ncs_b) begin
                    if (sclk_b) begin
                        hi_run_b = p_clk_b ? hi_run_b + 1 : 1;
                        if (hi_run_b > hi_max_b) hi_max_b = hi_run_b;
                    end else begin
                        lo_run_b = (!p_clk_b && !p_ncs_b) ? lo_run_b + 1 : 1;
                        if (lo_run_b > lo_max_b) lo_max_b = lo_run_b;
                    end
                end
                if (!p_clk_b && sclk_b) rises_b++;
                if (mosi_b !== p_mosi_b && sclk_b) mosi_viol_b++;
            end
            p_ncs_a = ncs_a; p_clk_a = sclk_a; p_mosi_a = mosi_a;
            p_ncs_b = ncs_b; p_clk_b = sclk_b; p_mosi_b = mosi_b;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge system_clk);
        #1;
    endtask

    task automatic xfer_a(input logic [WA-1:0] tx, input logic [WA-1:0] sw,
                          output logic [WA-1:0] got, output int lat, output int dw, output int tail);
        int n;
        n = 0;
        while (busy_a && n < 500) begin step(); n++; end
        slv_word  = sw;
        mosi_in_a = tx;
        start_a   = 1'b1;
        step();
        start_a   = 1'b0;
        mosi_in_a = WA'($urandom);
        lat = 1;
        while (!done_a && lat < 500) begin step(); lat++; end
        got  = miso_out_a;
        dw   = 0;
        tail = 0;
        while (busy_a && tail < 500) begin
            if (done_a) dw++;
            step();
            tail++;
        end
    endtask

    task automatic xfer_b(input logic [WB-1:0] tx, output logic [WB-1:0] got,
                          output int lat, output int dw, output int tail);
        int n;
        n = 0;
        while (busy_b && n < 500) begin step(); n++; end
        mosi_in_b = tx;
        start_b   = 1'b1;
        step();
        start_b   = 1'b0;
        mosi_in_b = WB'($urandom);
        lat = 1;
        while (!done_b && lat < 500) begin step(); lat++; end
        got  = miso_out_b;
        dw   = 0;
        tail = 0;
        while (busy_b && tail < 500) begin
            if (done_b) dw++;
            step();
            tail++;
        end
    endtask

    task automatic test_reset;
        system_rst_n = 1'b0;
        repeat (3) @(posedge system_clk);
        #1;
        checks++;
        if ({ncs_a, sclk_a, mosi_a, busy_a, done_a} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_pins_a got %b want 10000", {ncs_a, sclk_a, mosi_a, busy_a, done_a});
        end
        checks++;
        if (miso_out_a !== '0) begin
            errors++; $display("FAIL reset_value_a got %h want 0", miso_out_a);
        end
        checks++;
        if ({ncs_b, sclk_b, mosi_b, busy_b, done_b} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_pins_b got %b want 10000", {ncs_b, sclk_b, mosi_b, busy_b, done_b});
        end
        checks++;
        if (miso_out_b !== '0) begin
            errors++; $display("FAIL reset_value_b got %h want 0", miso_out_b);
        end
        system_rst_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_directed;
        logic [WA-1:0] got;
        int lat, dw, tail, v0;
        v0 = mosi_viol_a;
        xfer_a(4'b0110, 4'b1010, got, lat, dw, tail);
        checks++;
        if (got !== 4'b1010) begin errors++; $display("FAIL directed_miso got %b want 1010", got); end
        checks++;
        if (slv_rx !== 4'b0110) begin errors++; $display("FAIL directed_slave_rx got %b want 0110", slv_rx); end
        checks++;
        if (rises_a !== WA) begin errors++; $display("FAIL directed_rises got %0d want %0d", rises_a, WA); end
        checks++;
        if (lat !== LAT_A) begin errors++; $display("FAIL directed_latency got %0d want %0d", lat, LAT_A); end
        checks++;
        if (dw !== 1) begin errors++; $display("FAIL directed_done_width got %0d want 1", dw); end
        checks++;
        if (tail !== HA) begin errors++; $display("FAIL directed_busy_tail got %0d want %0d", tail, HA); end
        checks++;
        if (mosi_viol_a !== v0) begin
            errors++; $display("FAIL directed_mosi_while_clk_high got %0d want %0d", mosi_viol_a, v0);
        end
        repeat (5) step();
        checks++;
        if (miso_out_a !== 4'b1010) begin errors++; $display("FAIL directed_hold got %b want 1010", miso_out_a); end
    endtask

    task automatic test_sweep;
        logic [WA-1:0] got;
        int lat, dw, tail;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                xfer_a(WA'(i), WA'(j), got, lat, dw, tail);
                checks++;
                if (got !== WA'(j) || slv_rx !== WA'(i)) begin
                    errors++;
                    $display("FAIL sweep mosi=%h miso=%h got master=%h slave=%h", i, j, got, slv_rx);
                end
            end
        end
    endtask

    task automatic test_random_a;
        logic [WA-1:0] got, tx, sw;
        int lat, dw, tail;
        for (int k = 0; k < 16; k++) begin
            tx = WA'($urandom);
            sw = WA'($urandom);
            repeat ($urandom_range(0, 5)) step();
            xfer_a(tx, sw, got, lat, dw, tail);
            checks++;
            if (got !== sw || slv_rx !== tx || lat !== LAT_A || dw !== 1) begin
                errors++;
                $display("FAIL random_a got m=%h s=%h lat=%0d dw=%0d want m=%h s=%h lat=%0d dw=1",
                         got, slv_rx, lat, dw, sw, tx, LAT_A);
            end
        end
    endtask

    task automatic test_h1_loopback;
        logic [WB-1:0] got, tx;
        int lat, dw, tail, v0;
        v0 = mosi_viol_b;
        xfer_b(8'hA5, got, lat, dw, tail);
        checks++;
        if (got !== 8'hA5) begin errors++; $display("FAIL h1_value got %h want a5", got); end
        checks++;
        if (lat !== LAT_B) begin errors++; $display("FAIL h1_latency got %0d want %0d", lat, LAT_B); end
        checks++;
        if (rises_b !== WB) begin errors++; $display("FAIL h1_rises got %0d want %0d", rises_b, WB); end
        checks++;
        if (hi_max_b !== HB || lo_max_b !== HB) begin
            errors++; $display("FAIL h1_phase_len got hi=%0d lo=%0d want %0d", hi_max_b, lo_max_b, HB);
        end
        checks++;
        if (dw !== 1 || tail !== HB) begin
            errors++; $display("FAIL h1_done_tail got dw=%0d tail=%0d want 1 %0d", dw, tail, HB);
        end
        for (int k = 0; k < 8; k++) begin
            tx = WB'($urandom);
            xfer_b(tx, got, lat, dw, tail);
            checks++;
            if (got !== tx || lat !== LAT_B) begin
                errors++; $display("FAIL h1_random got %h lat=%0d want %h lat=%0d", got, lat, tx, LAT_B);
            end
        end
        checks++;
        if (mosi_viol_b !== v0) begin
            errors++; $display("FAIL h1_mosi_while_clk_high got %0d want %0d", mosi_viol_b, v0);
        end
    endtask

    task automatic test_ignore_start;
        logic [WA-1:0] got;
        int n, d0, f0;
        n = 0;
        while (busy_a && n < 500) begin step(); n++; end
        d0 = dones_a;
        f0 = frames_a;
        slv_word  = 4'b1001;
        mosi_in_a = 4'b0011;
        start_a   = 1'b1;
        step();
        start_a = 1'b0;
        repeat (10) step();
        mosi_in_a = 4'b1100;
        start_a   = 1'b1;
        step();
        start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL ignore_busy got %b want 1", busy_a); end
        n = 0;
        while (!done_a && n < 500) begin step(); n++; end
        got = miso_out_a;
        repeat (3 * HA + 4) step();
        checks++;
        if (dones_a - d0 !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", dones_a - d0); end
        checks++;
        if (frames_a - f0 !== 1) begin errors++; $display("FAIL ignore_frames got %0d want 1", frames_a - f0); end
        checks++;
        if (slv_rx !== 4'b0011 || got !== 4'b1001) begin
            errors++; $display("FAIL ignore_data got s=%b m=%b want 0011 1001", slv_rx, got);
        end
    endtask

    task automatic test_back_to_back;
        int n, d0, f0, g0;
        n = 0;
        while (busy_a && n < 500) begin step(); n++; end
        d0 = dones_a;
        f0 = frames_a;
        g0 = gap_log.size();
        slv_word  = 4'b0011;
        mosi_in_a = 4'b1101;
        start_a   = 1'b1;
        n = 0;
        while (frames_a - f0 < 3 && n < 2000) begin step(); n++; end
        start_a = 1'b0;
        n = 0;
        while ((dones_a - d0 < 3 || busy_a) && n < 2000) begin step(); n++; end
        repeat (2 * HA) step();
        checks++;
        if (dones_a - d0 !== 3) begin errors++; $display("FAIL b2b_done_count got %0d want 3", dones_a - d0); end
        checks++;
        if (frames_a - f0 !== 3) begin errors++; $display("FAIL b2b_frames got %0d want 3", frames_a - f0); end
        // ncs stays high through GAP (H cycles) plus the IDLE cycle that accepts the next start
        checks++;
        if (gap_log.size() < g0 + 3) begin
            errors++; $display("FAIL b2b_gap_log got %0d entries want %0d", gap_log.size() - g0, 3);
        end else if (gap_log[g0+1] !== HA + 1 || gap_log[g0+2] !== HA + 1) begin
            errors++;
            $display("FAIL b2b_ncs_gap got %0d %0d want %0d", gap_log[g0+1], gap_log[g0+2], HA + 1);
        end
        checks++;
        if (slv_rx !== 4'b1101 || miso_out_a !== 4'b0011) begin
            errors++; $display("FAIL b2b_data got s=%b m=%b want 1101 0011", slv_rx, miso_out_a);
        end
    endtask

    task automatic test_reset_mid;
        logic [WA-1:0] got;
        int n, d0, lat, dw, tail;
        n = 0;
        while (busy_a && n < 500) begin step(); n++; end
        slv_word  = 4'b1100;
        mosi_in_a = 4'b0101;
        start_a   = 1'b1;
        step();
        start_a = 1'b0;
        step();
        d0 = dones_a;
        n = 0;
        while (rises_a < 3 && n < 500) begin step(); n++; end
        checks++;
        if (sclk_a !== 1'b1 || rises_a !== 3) begin
            errors++; $display("FAIL rstmid_reach_high got clk=%b rises=%0d want 1 3", sclk_a, rises_a);
        end
        #2;
        system_rst_n = 1'b0;
        #1;
        checks++;
        if ({ncs_a, sclk_a, mosi_a, busy_a, done_a} !== 5'b10000) begin
            errors++;
            $display("FAIL rstmid_pins got %b want 10000", {ncs_a, sclk_a, mosi_a, busy_a, done_a});
        end
        repeat (3) @(posedge system_clk);
        #1;
        system_rst_n = 1'b1;
        repeat (2) step();
        checks++;
        if (dones_a !== d0 || miso_out_a !== '0) begin
            errors++; $display("FAIL rstmid_no_done got dones=%0d val=%h want %0d 0", dones_a - d0, miso_out_a, 0);
        end
        xfer_a(4'b1001, 4'b0110, got, lat, dw, tail);
        checks++;
        if (got !== 4'b0110 || slv_rx !== 4'b1001 || lat !== LAT_A) begin
            errors++;
            $display("FAIL rstmid_after got m=%b s=%b lat=%0d want 0110 1001 %0d", got, slv_rx, lat, LAT_A);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sweep();
        test_random_a();
        test_h1_loopback();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
